// File: rtl/demux_scan_if.sv
// demux_scan_if: control/status bundle between a run requester (master) and demux_scan_ctrl (slave)
//   start, mode_single, chan_sel[2:0], dwell[DWELL_W-1:0], stop : requests from master
//   i, s[2:0]                                                   : registered demux drive
//   busy, done, aborted                                         : run status
interface demux_scan_if #(
    parameter int DWELL_W = 8
);
    logic               start;
    logic               mode_single;
    logic [2:0]         chan_sel;
    logic [DWELL_W-1:0] dwell;
    logic               stop;
    logic               i;
    logic [2:0]         s;
    logic               busy;
    logic               done;
    logic               aborted;
    modport master (
        output start, mode_single, chan_sel, dwell, stop,
        input  i, s, busy, done, aborted
    );
    modport slave (
        input  start, mode_single, chan_sel, dwell, stop,
        output i, s, busy, done, aborted
    );
endinterface

// File: rtl/demux_scan_ctrl.sv
// demux_scan_ctrl: break-before-make sequencer driving the data input and select of a 1x8 demux
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : demux_scan_if.slave (start/mode_single/chan_sel/dwell/stop in; i/s/busy/done/aborted out)
module demux_scan_ctrl #(
    parameter int DWELL_W = 8
) (
    input  logic        clk,
    input  logic        rst,
    demux_scan_if.slave bus
);
    typedef enum logic [2:0] {IDLE, SETUP, DRIVE, HOLD, DONE} state_t;
    state_t             state, state_n;
    logic               single, single_n;
    logic [DWELL_W-1:0] dwell_c, dwell_c_n;
    logic [DWELL_W-1:0] cnt, cnt_n;
    logic [2:0]         s_n;
    logic               aborted_n;
    logic               run;
    assign run = state inside {SETUP, DRIVE, HOLD};
    always_comb begin
        state_n   = state;
        single_n  = single;
        dwell_c_n = dwell_c;
        cnt_n     = cnt;
        s_n       = bus.s;
        aborted_n = bus.aborted;
        case (state)
            IDLE: if (bus.start) begin
                state_n   = SETUP;
                single_n  = bus.mode_single;
                dwell_c_n = (bus.dwell == '0) ? DWELL_W'(1) : bus.dwell;
                s_n       = bus.mode_single ? bus.chan_sel : 3'd0;
                aborted_n = 1'b0;
            end
            SETUP: begin
                state_n = DRIVE;
                cnt_n   = dwell_c;
            end
            DRIVE: begin
                state_n = (cnt == DWELL_W'(1)) ? HOLD : DRIVE;
                cnt_n   = cnt - DWELL_W'(1);
            end
            HOLD: begin
                state_n = (single || bus.s == 3'd7) ? DONE : SETUP;
                s_n     = (single || bus.s == 3'd7) ? bus.s : bus.s + 3'd1;
            end
            default: state_n = IDLE;
        endcase
        // abort wins over every normal transition and freezes s on the active channel
        if (bus.stop && run) begin
            state_n   = DONE;
            s_n       = bus.s;
            aborted_n = 1'b1;
        end
    end
    // outputs are decoded from the next state so they change on the same edge as the state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            single      <= 1'b0;
            dwell_c     <= '0;
            cnt         <= '0;
            bus.s       <= 3'd0;
            bus.i       <= 1'b0;
            bus.busy    <= 1'b0;
            bus.done    <= 1'b0;
            bus.aborted <= 1'b0;
        end else begin
            state       <= state_n;
            single      <= single_n;
            dwell_c     <= dwell_c_n;
            cnt         <= cnt_n;
            bus.s       <= s_n;
            bus.i       <= state_n == DRIVE;
            bus.busy    <= state_n inside {SETUP, DRIVE, HOLD};
            bus.done    <= state_n == DONE;
            bus.aborted <= aborted_n;
        end
    end
endmodule

// File: tb/tb_demux_scan_ctrl.sv
// tb_demux_scan_ctrl: randomized and directed runs of demux_scan_ctrl checked against a timing model
module tb_demux_scan_ctrl;
    localparam int DWELL_W = 8;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    demux_scan_if #(.DWELL_W(DWELL_W)) bus ();
    demux_scan_ctrl #(.DWELL_W(DWELL_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask
    // Expected outputs t cycles after the accepting edge. A channel occupies dwell+2 cycles:
    // one setup cycle, dwell drive cycles, one hold cycle. k >= 0 means stop was seen during cycle k.
    function automatic void model(input bit single, input int ch, input int d, input int k, input int t,
                                  output int ei, output int es, output int eb, output int edn, output int eab);
        int de, per, fin, tl;
        de  = (d == 0) ? 1 : d;
        per = de + 2;
        fin = (k >= 0) ? k + 1 : (single ? 1 : 8) * per;
        tl  = (t < fin) ? t : fin - 1;
        es  = single ? ch : tl / per;
        ei  = int'(t < fin && (t % per) >= 1 && (t % per) <= de);
        eb  = int'(t < fin);
        edn = int'(t == fin);
        eab = int'(k >= 0 && t >= fin);
    endfunction
    // Called right after a negedge with the DUT idle; returns right after the negedge of the idle cycle.
    task automatic run(input bit single, input int ch, input int d, input int k, input bit hold);
        int de, fin, ei, es, eb, edn, eab;
        de  = (d == 0) ? 1 : d;
        fin = (k >= 0) ? k + 1 : (single ? 1 : 8) * (de + 2);
        bus.mode_single = single;
        bus.chan_sel    = 3'(ch);
        bus.dwell       = DWELL_W'(d);
        bus.start       = 1'b1;
        bus.stop        = 1'b0;
        @(posedge clk);
        for (int t = 0; t <= fin + 1; t++) begin
            @(negedge clk);
            model(single, ch, d, k, t, ei, es, eb, edn, eab);
            chk("i", 32'(bus.i), ei);
            chk("s", 32'(bus.s), es);
            chk("busy", 32'(bus.busy), eb);
            chk("done", 32'(bus.done), edn);
            chk("aborted", 32'(bus.aborted), eab);
            bus.start = hold || (t < fin && $urandom_range(0, 5) == 0);
            bus.stop  = (t == k);
            if (t < fin) begin
                bus.chan_sel    = 3'($urandom);
                bus.dwell       = DWELL_W'($urandom);
                bus.mode_single = 1'($urandom);
            end
        end
        bus.start = hold;
        bus.stop  = 1'b0;
    endtask
    // s may only move while i is low both before and after the edge
    logic       pi;
    logic [2:0] ps;
    bit         armed = 1'b0;
    always @(negedge clk) begin
        if (rst) armed = 1'b0;
        else begin
            if (armed && bus.s != ps) chk("bbm", 32'({pi, bus.i}), 0);
            armed = 1'b1;
            pi    = bus.i;
            ps    = bus.s;
        end
    end
    initial begin
        int tot, k, d;
        bit single;
        bus.start       = 1'b0;
        bus.stop        = 1'b0;
        bus.mode_single = 1'b0;
        bus.chan_sel    = 3'd0;
        bus.dwell       = '0;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        chk("rst_i", 32'(bus.i), 0);
        chk("rst_s", 32'(bus.s), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_aborted", 32'(bus.aborted), 0);
        run(1'b1, 5, 3, -1, 1'b0);
        run(1'b0, 0, 2, -1, 1'b0);
        run(1'b0, 0, 0, -1, 1'b0);
        run(1'b1, 6, 255, -1, 1'b0);
        run(1'b0, 0, 4, 20, 1'b0);
        run(1'b1, 1, 1, -1, 1'b1);
        run(1'b1, 2, 2, 0, 1'b1);
        run(1'b0, 0, 1, -1, 1'b0);
        for (int n = 0; n < 25; n++) begin
            single = 1'($urandom);
            d      = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 6));
            tot    = (single ? 1 : 8) * (((d == 0) ? 1 : d) + 2);
            k      = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, tot - 1)) : -1;
            run(single, int'($urandom_range(0, 7)), d, k, 1'($urandom));
        end
        bus.start       = 1'b1;
        bus.mode_single = 1'b1;
        bus.chan_sel    = 3'd2;
        bus.dwell       = DWELL_W'(10);
        @(posedge clk);
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_i", 32'(bus.i), 0);
        chk("mid_rst_s", 32'(bus.s), 0);
        chk("mid_rst_busy", 32'(bus.busy), 0);
        chk("mid_rst_done", 32'(bus.done), 0);
        @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        for (int t = 0; t < 6; t++) begin
            @(negedge clk);
            chk("post_rst_done", 32'(bus.done), 0);
            chk("post_rst_busy", 32'(bus.busy), 0);
            chk("post_rst_i", 32'(bus.i), 0);
        end
        run(1'b0, 0, 3, -1, 1'b0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
